// File: rtl/dev_bus_arbiter_if.sv
// Bundle of the two master ports and the shared bridge-side port of dev_bus_arbiter.
// The arbiter connects through the slave modport; master is the requester-side view.
interface dev_bus_arbiter_if;
    logic        m0_req,   m1_req;
    logic [29:0] m0_addr,  m1_addr;
    logic [31:0] m0_wdata, m1_wdata;
    logic        m0_we,    m1_we;
    logic [3:0]  m0_be,    m1_be;
    logic [31:0] m0_rdata, m1_rdata;
    logic        m0_ack,   m1_ack;
    logic [29:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_we;
    logic [3:0]  bus_be;
    logic [31:0] bus_rdata;
    logic [1:0]  bus_owner;

    modport slave (
        input  m0_req, m1_req, m0_addr, m1_addr, m0_wdata, m1_wdata,
        input  m0_we, m1_we, m0_be, m1_be, bus_rdata,
        output m0_rdata, m1_rdata, m0_ack, m1_ack,
        output bus_addr, bus_wdata, bus_we, bus_be, bus_owner
    );

    modport master (
        output m0_req, m1_req, m0_addr, m1_addr, m0_wdata, m1_wdata,
        output m0_we, m1_we, m0_be, m1_be, bus_rdata,
        input  m0_rdata, m1_rdata, m0_ack, m1_ack,
        input  bus_addr, bus_wdata, bus_we, bus_be, bus_owner
    );
endinterface

// File: rtl/dev_bus_arbiter.sv
// Two-master arbiter for the bridge device port: IDLE -> BUSY -> ACK per transfer.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority with burst limit.
module dev_bus_arbiter #(
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             reset,
    dev_bus_arbiter_if.slave bif
);
    typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

    state_t      state, state_nxt;
    logic        sel;
    logic        grant;
    logic        win1;
    logic [31:0] rd0, rd1;
`ifdef ARB_ROUND_ROBIN_EN
    logic        last;
`else
    logic [3:0]  burst;
`endif

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        grant         = 1'b0;
        win1          = 1'b0;
        bif.bus_addr  = '0;
        bif.bus_wdata = '0;
        bif.bus_we    = 1'b0;
        bif.bus_be    = '0;
        bif.bus_owner = 2'b00;
        bif.m0_ack    = 1'b0;
        bif.m1_ack    = 1'b0;
        case (state)
            IDLE: begin
                if (bif.m0_req || bif.m1_req) begin
                    grant     = 1'b1;
                    state_nxt = BUSY;
`ifdef ARB_ROUND_ROBIN_EN
                    // last reset to 1 so the first contended grant goes to master 0
                    win1 = bif.m1_req && (!bif.m0_req || !last);
`else
                    win1 = bif.m1_req && (!bif.m0_req || (burst == 4'(MAX_BURST)));
`endif
                end
            end
            BUSY: begin
                state_nxt     = ACK;
                bif.bus_addr  = sel ? bif.m1_addr  : bif.m0_addr;
                bif.bus_wdata = sel ? bif.m1_wdata : bif.m0_wdata;
                bif.bus_we    = sel ? bif.m1_we    : bif.m0_we;
                bif.bus_be    = sel ? bif.m1_be    : bif.m0_be;
                bif.bus_owner = sel ? 2'b10 : 2'b01;
            end
            ACK: begin
                state_nxt  = IDLE;
                bif.m0_ack = !sel;
                bif.m1_ack = sel;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sel <= 1'b0;
            rd0 <= '0;
            rd1 <= '0;
        end else begin
            if (grant) sel <= win1;
            if (state == BUSY) begin
                if (sel) rd1 <= bif.bus_rdata;
                else     rd0 <= bif.bus_rdata;
            end
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk) begin
        if (reset)      last <= 1'b1;
        else if (grant) last <= win1;
    end
`else
    // Counts master-0 grants that made a waiting master 1 wait longer
    always_ff @(posedge clk) begin
        if (reset) begin
            burst <= '0;
        end else if (grant) begin
            if (win1 || !bif.m1_req)            burst <= '0;
            else if (burst != 4'(MAX_BURST))    burst <= burst + 4'd1;
        end
    end
`endif

    assign bif.m0_rdata = rd0;
    assign bif.m1_rdata = rd1;
endmodule

// File: tb/tb_dev_bus_arbiter.sv
// Self-checking bench for dev_bus_arbiter: directed scenarios plus randomized traffic
// against a transaction-level scoreboard of grants, bus cycles and acks.
module tb_dev_bus_arbiter;
    localparam int MAXB = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   pass_cnt = 0;
    int   total = 0;
    logic        rd_fixed_en = 1'b1;
    logic [31:0] rd_fixed = 32'h0;

    dev_bus_arbiter_if bif();

    dev_bus_arbiter #(.MAX_BURST(MAXB)) dut (
        .clk   (clk),
        .reset (reset),
        .bif   (bif)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] hashf(input logic [29:0] a);
        return {a, 2'b11} ^ 32'h5A5A_1234 ^ {a[15:0], a[29:14]};
    endfunction

    assign bif.bus_rdata = rd_fixed_en ? rd_fixed : hashf(bif.bus_addr);

    wire [68:0] bus_all = {bif.bus_addr, bif.bus_wdata, bif.bus_we, bif.bus_be, bif.bus_owner};

    task automatic clr_inputs();
        bif.m0_req = 0; bif.m0_addr = '0; bif.m0_wdata = '0; bif.m0_we = 0; bif.m0_be = '0;
        bif.m1_req = 0; bif.m1_addr = '0; bif.m1_wdata = '0; bif.m1_we = 0; bif.m1_be = '0;
    endtask

    // Leaves the caller 1 time unit after a rising edge with reset released.
    task automatic do_reset();
        reset = 1'b1;
        clr_inputs();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clr_inputs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (bus_all !== '0) $display("FAIL reset_bus got %h want 0", bus_all); else pass_cnt++;
        total++; if (bif.m0_ack !== 1'b0) $display("FAIL reset_m0_ack got %b want 0", bif.m0_ack); else pass_cnt++;
        total++; if (bif.m1_ack !== 1'b0) $display("FAIL reset_m1_ack got %b want 0", bif.m1_ack); else pass_cnt++;
        total++; if (bif.m0_rdata !== 32'h0) $display("FAIL reset_m0_rdata got %h want 0", bif.m0_rdata); else pass_cnt++;
        total++; if (bif.m1_rdata !== 32'h0) $display("FAIL reset_m1_rdata got %h want 0", bif.m1_rdata); else pass_cnt++;
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_single_read();
        rd_fixed_en = 1'b1;
        rd_fixed    = 32'hDEADBEEF;
        bif.m0_req = 1; bif.m0_addr = 30'h00001FC0; bif.m0_we = 0; bif.m0_be = 4'hF; bif.m0_wdata = 32'h0;
        @(negedge clk);
        total++; if (bus_all !== '0) $display("FAIL rd_idle_bus got %h want 0", bus_all); else pass_cnt++;
        @(negedge clk);
        total++; if (bif.bus_owner !== 2'b01) $display("FAIL rd_owner got %b want 01", bif.bus_owner); else pass_cnt++;
        total++; if (bif.bus_we !== 1'b0) $display("FAIL rd_we got %b want 0", bif.bus_we); else pass_cnt++;
        total++; if (bif.bus_addr !== 30'h00001FC0) $display("FAIL rd_addr got %h want 1fc0", bif.bus_addr); else pass_cnt++;
        total++; if (bif.bus_be !== 4'hF) $display("FAIL rd_be got %h want f", bif.bus_be); else pass_cnt++;
        total++; if (bif.m0_ack !== 1'b0) $display("FAIL rd_early_ack got %b want 0", bif.m0_ack); else pass_cnt++;
        @(negedge clk);
        total++; if (bif.m0_ack !== 1'b1) $display("FAIL rd_ack got %b want 1", bif.m0_ack); else pass_cnt++;
        total++; if (bif.m0_rdata !== 32'hDEADBEEF) $display("FAIL rd_data got %h want deadbeef", bif.m0_rdata); else pass_cnt++;
        total++; if (bus_all !== '0) $display("FAIL rd_ack_bus got %h want 0", bus_all); else pass_cnt++;
        bif.m0_req = 0;
        @(negedge clk);
        total++; if (bif.m0_ack !== 1'b0) $display("FAIL rd_ack_drop got %b want 0", bif.m0_ack); else pass_cnt++;
        total++; if (bif.m1_rdata !== 32'h0) $display("FAIL rd_m1_rdata_hold got %h want 0", bif.m1_rdata); else pass_cnt++;
    endtask

    task automatic test_single_write();
        @(posedge clk); #1;
        rd_fixed = 32'hCAFE0001;
        bif.m1_req = 1; bif.m1_addr = 30'h00001FC8; bif.m1_wdata = 32'h12345678; bif.m1_we = 1; bif.m1_be = 4'hF;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 1) begin
                total++;
                if (bus_all !== {30'h00001FC8, 32'h12345678, 1'b1, 4'hF, 2'b10})
                    $display("FAIL wr_bus cyc%0d got %h want %h", i, bus_all, {30'h00001FC8, 32'h12345678, 1'b1, 4'hF, 2'b10});
                else pass_cnt++;
            end else begin
                total++; if (bus_all !== '0) $display("FAIL wr_quiet cyc%0d got %h want 0", i, bus_all); else pass_cnt++;
            end
            total++;
            if ({bif.m1_ack, bif.m0_ack} !== ((i == 2) ? 2'b10 : 2'b00))
                $display("FAIL wr_ack cyc%0d got %b want %b", i, {bif.m1_ack, bif.m0_ack}, (i == 2) ? 2'b10 : 2'b00);
            else pass_cnt++;
            if (i == 2) bif.m1_req = 0;
        end
        total++; if (bif.m1_rdata !== 32'hCAFE0001) $display("FAIL wr_m1_rdata got %h want cafe0001", bif.m1_rdata); else pass_cnt++;
        total++; if (bif.m0_rdata !== 32'hDEADBEEF) $display("FAIL wr_m0_rdata_hold got %h want deadbeef", bif.m0_rdata); else pass_cnt++;
    endtask

    task automatic test_contention();
        logic [1:0] want;
        int t;
        do_reset();
        bif.m0_req = 1; bif.m0_addr = 30'h1; bif.m0_we = 0; bif.m0_be = 4'h1;
        bif.m1_req = 1; bif.m1_addr = 30'h2; bif.m1_we = 0; bif.m1_be = 4'h2;
        for (int g = 0; g < 10; g++) begin
`ifdef ARB_ROUND_ROBIN_EN
            want = (g % 2 == 0) ? 2'b01 : 2'b10;
`else
            want = (g % (MAXB + 1) == MAXB) ? 2'b10 : 2'b01;
`endif
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (bif.bus_owner == 2'b00 && t < 10);
            total++;
            if (bif.bus_owner !== want) $display("FAIL contention_grant%0d got %b want %b", g, bif.bus_owner, want);
            else pass_cnt++;
        end
        clr_inputs();
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int t;
        bif.m0_req = 1; bif.m0_addr = 30'h55; bif.m0_wdata = 32'hA5A5_0F0F; bif.m0_we = 1; bif.m0_be = 4'h3;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (bif.bus_owner != 2'b01 && t < 10);
        total++; if (bif.bus_owner !== 2'b01) $display("FAIL rstmid_busy got %b want 01", bif.bus_owner); else pass_cnt++;
        reset = 1'b1;
        @(negedge clk);
        total++; if (bif.m0_ack !== 1'b0) $display("FAIL rstmid_noack got %b want 0", bif.m0_ack); else pass_cnt++;
        total++; if (bus_all !== '0) $display("FAIL rstmid_bus got %h want 0", bus_all); else pass_cnt++;
        reset = 1'b0;
        @(negedge clk);
        total++;
        if ({bif.bus_owner, bif.bus_we, bif.bus_addr} !== {2'b01, 1'b1, 30'h55})
            $display("FAIL rstmid_retry got %h want %h", {bif.bus_owner, bif.bus_we, bif.bus_addr}, {2'b01, 1'b1, 30'h55});
        else pass_cnt++;
        @(negedge clk);
        total++; if (bif.m0_ack !== 1'b1) $display("FAIL rstmid_ack got %b want 1", bif.m0_ack); else pass_cnt++;
        bif.m0_req = 0;
    endtask

    task automatic test_idle_quiet();
        clr_inputs();
        @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            total++;
            if ({bif.bus_we, bif.bus_be, bif.m0_ack, bif.m1_ack, bif.bus_owner} !== 9'h0)
                $display("FAIL idle_quiet cyc%0d got %h want 0", i,
                         {bif.bus_we, bif.bus_be, bif.m0_ack, bif.m1_ack, bif.bus_owner});
            else pass_cnt++;
        end
    endtask

    task automatic test_random();
        logic        r[2], w[2], done[2];
        logic [29:0] a[2];
        logic [31:0] wd[2];
        logic [3:0]  be[2];
        logic [1:0]  e_own[4], e_ack[4];
        logic [29:0] e_addr[4];
        logic [31:0] e_wd[4], e_rdv[4];
        logic        e_we[4];
        logic [3:0]  e_be[4];
        logic [31:0] exp_rd[2];
        int          free_at, streak, win, s, s1, s2;
        logic        last_win;
        for (int i = 0; i < 4; i++) begin
            e_own[i] = 0; e_ack[i] = 0; e_addr[i] = 0; e_wd[i] = 0; e_rdv[i] = 0; e_we[i] = 0; e_be[i] = 0;
        end
        for (int m = 0; m < 2; m++) begin
            r[m] = 0; w[m] = 0; done[m] = 0; a[m] = 0; wd[m] = 0; be[m] = 0; exp_rd[m] = 0;
        end
        free_at = 0; streak = 0; last_win = 1'b1;
        rd_fixed_en = 1'b0;
        do_reset();
        for (int k = 0; k < 400; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            for (int m = 0; m < 2; m++) begin
                if (done[m]) begin
                    r[m] = 0;
                    done[m] = 0;
                end
                if (!r[m] && $urandom_range(0, 2) == 0) begin
                    r[m] = 1; a[m] = 30'($urandom); wd[m] = $urandom; w[m] = 1'($urandom); be[m] = 4'($urandom);
                end
            end
            bif.m0_req = r[0]; bif.m0_addr = a[0]; bif.m0_wdata = wd[0]; bif.m0_we = w[0]; bif.m0_be = be[0];
            bif.m1_req = r[1]; bif.m1_addr = a[1]; bif.m1_wdata = wd[1]; bif.m1_we = w[1]; bif.m1_be = be[1];
            @(negedge clk);
            if (k >= free_at && (r[0] || r[1])) begin
`ifdef ARB_ROUND_ROBIN_EN
                win = (r[1] && (!r[0] || !last_win)) ? 1 : 0;
                last_win = (win == 1);
`else
                win = (r[1] && (!r[0] || streak == MAXB)) ? 1 : 0;
                if (win == 1 || !r[1]) streak = 0;
                else if (streak < MAXB) streak++;
`endif
                s1 = (k + 1) % 4;
                s2 = (k + 2) % 4;
                e_own[s1] = (win == 1) ? 2'b10 : 2'b01;
                e_addr[s1] = a[win]; e_wd[s1] = wd[win]; e_we[s1] = w[win]; e_be[s1] = be[win];
                e_ack[s2] = (win == 1) ? 2'b10 : 2'b01;
                e_rdv[s2] = hashf(a[win]);
                free_at = k + 3;
            end
            s = k % 4;
            for (int m = 0; m < 2; m++) if (e_ack[s][m]) begin
                exp_rd[m] = e_rdv[s];
                done[m] = 1;
            end
            total++; if (bif.bus_owner !== e_own[s]) $display("FAIL rnd_owner k%0d got %b want %b", k, bif.bus_owner, e_own[s]); else pass_cnt++;
            total++; if (bif.bus_addr !== e_addr[s]) $display("FAIL rnd_addr k%0d got %h want %h", k, bif.bus_addr, e_addr[s]); else pass_cnt++;
            total++; if (bif.bus_wdata !== e_wd[s]) $display("FAIL rnd_wdata k%0d got %h want %h", k, bif.bus_wdata, e_wd[s]); else pass_cnt++;
            total++; if (bif.bus_we !== e_we[s]) $display("FAIL rnd_we k%0d got %b want %b", k, bif.bus_we, e_we[s]); else pass_cnt++;
            total++; if (bif.bus_be !== e_be[s]) $display("FAIL rnd_be k%0d got %h want %h", k, bif.bus_be, e_be[s]); else pass_cnt++;
            total++; if ({bif.m1_ack, bif.m0_ack} !== e_ack[s]) $display("FAIL rnd_ack k%0d got %b want %b", k, {bif.m1_ack, bif.m0_ack}, e_ack[s]); else pass_cnt++;
            total++; if (bif.m0_rdata !== exp_rd[0]) $display("FAIL rnd_m0_rdata k%0d got %h want %h", k, bif.m0_rdata, exp_rd[0]); else pass_cnt++;
            total++; if (bif.m1_rdata !== exp_rd[1]) $display("FAIL rnd_m1_rdata k%0d got %h want %h", k, bif.m1_rdata, exp_rd[1]); else pass_cnt++;
            e_own[s] = 0; e_ack[s] = 0; e_addr[s] = 0; e_wd[s] = 0; e_we[s] = 0; e_be[s] = 0;
        end
        clr_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        clr_inputs();
        test_reset();
        test_single_read();
        test_single_write();
        test_contention();
        test_reset_mid();
        test_idle_quiet();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
